hssl_link_controller: RTL and testbench
=======================================

# hssl_link_controller

Bring-up and recovery sequencer for one HSSL link. It holds the transceiver in reset, releases it, and waits for 8b/10b sync and then for the spiNNlink handshake. It drives the spiNNlink `stop` control and gates one outgoing packet stream until the link is up. On any failure it backs off and retries, and after too many consecutive failures it latches a fault. It sits between the board control/configuration logic and the HSSL interface block, on the same clock.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles the transceiver reset is held per attempt (≥1).
- `SYNC_TIMEOUT`, 1024: max cycles in WAIT_SYNC (≥1).
- `HSHAKE_TIMEOUT`, 4096: max cycles in WAIT_HSHAKE (≥1).
- `BACKOFF_CYCLES`, 256: wait after a failure before retrying (≥1).
- `MAX_RETRIES`, 8: consecutive failures before FAULT; 0 = retry forever.
- `PACKET_BITS`, 72: gated packet width.
- `DROP_WHEN_DOWN`, 0: 1 = discard packets while the link is down; 0 = back-pressure.

Ports (one clock; `reset` is asynchronous, active-high):
- `clk` in 1: clock.
- `reset` in 1: async active-high reset.
- `enable_in` in 1: 1 = bring up / keep the link; 0 = return to IDLE.
- `loss_of_sync_state_in` in 2: sync state from the HSSL interface; 2'b00 = sync acquired.
- `handshake_complete_in` in 1: spiNNlink handshake done.
- `version_mismatch_in` in 1: peer version incompatible.
- `gt_reset_out` out 1: transceiver/HSSL datapath reset request.
- `stop_out` out 1: drives spiNNlink `stop`.
- `link_up_out` out 1: high in LINK_UP.
- `fault_out` out 1: high in FAULT.
- `state_out` out 3: current state code.
- `fail_cnt_out` out 8: consecutive failures, saturating at 255.
- `link_drops_out` out 16: total exits from LINK_UP, saturating at 65535.
- `pkt_data_in` in PACKET_BITS, `pkt_vld_in` in 1, `pkt_rdy_out` out 1: upstream packet stream.
- `pkt_data_out` out PACKET_BITS, `pkt_vld_out` out 1, `pkt_rdy_in` in 1: to HSSL tx channel.

## Operation
State codes: IDLE=0, RESET_GT=1, WAIT_SYNC=2, WAIT_HSHAKE=3, LINK_UP=4, BACKOFF=5, FAULT=6. Codes 7 and any illegal code go to IDLE.

Timer and entry rules:
- One `timer` is cleared on every state entry and increments each cycle while in RESET_GT, WAIT_SYNC, WAIT_HSHAKE and BACKOFF.
- Its width is `$clog2` of the largest of RST_CYCLES, SYNC_TIMEOUT, HSHAKE_TIMEOUT and BACKOFF_CYCLES, plus 1.
- `enable_in`=0 in any state forces IDLE on the next edge. This has highest priority and does not count as a failure.

Transitions (priority in listed order):
- IDLE: `enable_in`=1 → RESET_GT.
- RESET_GT: timer==RST_CYCLES-1 → WAIT_SYNC.
- WAIT_SYNC: `loss_of_sync_state_in`==2'b00 → WAIT_HSHAKE; else timer==SYNC_TIMEOUT-1 → fail.
- WAIT_HSHAKE, in this order:
  - `version_mismatch_in` → FAULT;
  - `loss_of_sync_state_in`!=2'b00 → fail;
  - `handshake_complete_in` → LINK_UP;
  - timer==HSHAKE_TIMEOUT-1 → fail.
- LINK_UP: `loss_of_sync_state_in`!=2'b00 or `handshake_complete_in`=0 → fail. A link drop also increments `link_drops_out` (saturating).
- BACKOFF: timer==BACKOFF_CYCLES-1 → RESET_GT.
- FAULT: leaves only via `enable_in`=0 → IDLE.

Fail handling:
- `fail_cnt` increments, saturating at 255.
- If MAX_RETRIES≠0 and the incremented count ≥ MAX_RETRIES → FAULT; otherwise → BACKOFF.
- `fail_cnt` clears on entry to LINK_UP or IDLE.

Outputs as a function of state:
- `gt_reset_out`=1 in IDLE, RESET_GT, BACKOFF and FAULT; 0 otherwise.
- `stop_out`=0 only in LINK_UP.
- `link_up_out`=1 only in LINK_UP.
- `fault_out`=1 only in FAULT.

Packet gate (combinational from the registered `link_up_out`):
- Link up: `pkt_data_out`=`pkt_data_in`, `pkt_vld_out`=`pkt_vld_in`, `pkt_rdy_out`=`pkt_rdy_in`.
- Link down: `pkt_vld_out`=0, `pkt_data_out`=`pkt_data_in`, and `pkt_rdy_out`=DROP_WHEN_DOWN (packets are discarded if 1, stalled if 0).

## Timing
- Reset values: state IDLE, `gt_reset_out`=1, `stop_out`=1, `link_up_out`=0, `fault_out`=0, `fail_cnt_out`=0, `link_drops_out`=0, timer 0, `pkt_vld_out`=0.
- All status outputs are registered and change on the same edge as the state register. There is no added latency between `state_out` and its decoded outputs.
- State durations:
  - RESET_GT lasts exactly RST_CYCLES cycles.
  - BACKOFF lasts exactly BACKOFF_CYCLES cycles.
  - A timeout fail occurs on the edge after the SYNC_TIMEOUT-th (or HSHAKE_TIMEOUT-th) cycle in state.
- Inputs are sampled on every edge. A condition present in the first cycle of a state acts on the following edge, e.g. sync already 00 on WAIT_SYNC entry → WAIT_HSHAKE after 1 cycle.
- Simultaneous events resolve by the priority order above. Examples: mismatch plus handshake → FAULT; `enable_in`=0 plus timeout → IDLE, with no count change.
- Asserting `reset` mid-operation clears everything asynchronously. `gt_reset_out` is 1 immediately.
- Packet gate: zero-cycle combinational path. A packet held by back-pressure when the link drops remains pending; `pkt_vld_out` goes 0 in the same cycle as `link_up_out`.

## Test plan
Parameters for all scenarios: RST_CYCLES=4, SYNC_TIMEOUT=8, HSHAKE_TIMEOUT=8, BACKOFF_CYCLES=3, MAX_RETRIES=2.
- Normal bring-up: enable=1, sync=00 at cycle 6, handshake at cycle 9.
  - Required: `gt_reset_out` high for 4 cycles after leaving IDLE.
  - Required: LINK_UP reached; `stop_out`=0; `fail_cnt_out`=0.
- Sync never arrives (sync=10 throughout).
  - Required: WAIT_SYNC for 8 cycles, then BACKOFF for 3, then RESET_GT, with `fail_cnt_out`=1.
  - Required: the second timeout enters FAULT with `fail_cnt_out`=2 and `fault_out`=1.
- Version mismatch and handshake asserted together in WAIT_HSHAKE.
  - Required: FAULT.
  - Required: enable=0 → IDLE next cycle; enable=1 → RESET_GT with `fail_cnt_out`=0.
- Link drop: in LINK_UP, sync goes 01 for 1 cycle.
  - Required: `link_drops_out` 0→1, then BACKOFF, then the full retry sequence.
  - Required: the counter saturates at 65535 when preloaded via forced drops.
- Packet gate: with DROP_WHEN_DOWN=0 and 1, send packets with `pkt_vld_in`=1 before and after LINK_UP.
  - Link down: `pkt_vld_out`=0; `pkt_rdy_out` equals DROP_WHEN_DOWN.
  - Link up: data passes unchanged, e.g. 72'h12_3456_789A_BCDE_F012.
- Reset mid-WAIT_HSHAKE (timer=5).
  - Required: all outputs return to reset values asynchronously; the sequence restarts cleanly.

Source files
------------

// File: rtl/hssl_link_controller.sv
// Bring-up and recovery sequencer for one HSSL link: transceiver reset, sync/handshake
// wait, retry with backoff, fault latching, and gating of one outgoing packet stream.
module hssl_link_controller #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned SYNC_TIMEOUT   = 1024,
  parameter int unsigned HSHAKE_TIMEOUT = 4096,
  parameter int unsigned BACKOFF_CYCLES = 256,
  parameter int unsigned MAX_RETRIES    = 8,
  parameter int unsigned PACKET_BITS    = 72,
  parameter bit          DROP_WHEN_DOWN = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable_in,
  input  logic [1:0]             loss_of_sync_state_in,
  input  logic                   handshake_complete_in,
  input  logic                   version_mismatch_in,
  output logic                   gt_reset_out,
  output logic                   stop_out,
  output logic                   link_up_out,
  output logic                   fault_out,
  output logic [2:0]             state_out,
  output logic [7:0]             fail_cnt_out,
  output logic [15:0]            link_drops_out,
  input  logic [PACKET_BITS-1:0] pkt_data_in,
  input  logic                   pkt_vld_in,
  output logic                   pkt_rdy_out,
  output logic [PACKET_BITS-1:0] pkt_data_out,
  output logic                   pkt_vld_out,
  input  logic                   pkt_rdy_in
);

  localparam int unsigned MAX_AB  = (RST_CYCLES > SYNC_TIMEOUT) ? RST_CYCLES : SYNC_TIMEOUT;
  localparam int unsigned MAX_CD  = (HSHAKE_TIMEOUT > BACKOFF_CYCLES) ? HSHAKE_TIMEOUT : BACKOFF_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned TIMER_W = $clog2(MAX_ALL) + 1;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_RESET_GT    = 3'd1,
    ST_WAIT_SYNC   = 3'd2,
    ST_WAIT_HSHAKE = 3'd3,
    ST_LINK_UP     = 3'd4,
    ST_BACKOFF     = 3'd5,
    ST_FAULT       = 3'd6
  } state_t;

  state_t               state_q, state_nxt;
  logic [TIMER_W-1:0]   timer_q, timer_nxt;
  logic [7:0]           fail_cnt_q, fail_cnt_nxt, fail_inc;
  logic [15:0]          link_drops_q, link_drops_nxt;
  logic                 gt_reset_nxt, stop_nxt, link_up_nxt, fault_nxt;
  logic                 do_fail;
  logic                 synced;

  // Next-state, counters and decoded status outputs
  always_comb begin
    state_nxt      = state_q;
    timer_nxt      = timer_q;
    fail_cnt_nxt   = fail_cnt_q;
    link_drops_nxt = link_drops_q;
    do_fail        = 1'b0;
    synced         = (loss_of_sync_state_in == 2'b00);
    fail_inc       = (fail_cnt_q == 8'hFF) ? 8'hFF : fail_cnt_q + 8'd1;

    if (!enable_in) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_nxt = ST_RESET_GT;
        ST_RESET_GT: if (timer_q == TIMER_W'(RST_CYCLES - 1)) state_nxt = ST_WAIT_SYNC;
        ST_WAIT_SYNC: begin
          if (synced) state_nxt = ST_WAIT_HSHAKE;
          else if (timer_q == TIMER_W'(SYNC_TIMEOUT - 1)) do_fail = 1'b1;
        end
        ST_WAIT_HSHAKE: begin
          if (version_mismatch_in) state_nxt = ST_FAULT;
          else if (!synced) do_fail = 1'b1;
          else if (handshake_complete_in) state_nxt = ST_LINK_UP;
          else if (timer_q == TIMER_W'(HSHAKE_TIMEOUT - 1)) do_fail = 1'b1;
        end
        ST_LINK_UP: begin
          if (!synced || !handshake_complete_in) begin
            do_fail        = 1'b1;
            link_drops_nxt = (link_drops_q == 16'hFFFF) ? 16'hFFFF : link_drops_q + 16'd1;
          end
        end
        ST_BACKOFF:  if (timer_q == TIMER_W'(BACKOFF_CYCLES - 1)) state_nxt = ST_RESET_GT;
        ST_FAULT:    state_nxt = ST_FAULT;
        default:     state_nxt = ST_IDLE;
      endcase
    end

    if (do_fail) begin
      fail_cnt_nxt = fail_inc;
      if ((MAX_RETRIES != 0) && (32'(fail_inc) >= MAX_RETRIES)) state_nxt = ST_FAULT;
      else state_nxt = ST_BACKOFF;
    end

    if ((state_nxt == ST_IDLE) || (state_nxt == ST_LINK_UP)) fail_cnt_nxt = 8'd0;

    // Timer restarts on every state entry and runs only in the timed states
    if (state_nxt != state_q) begin
      timer_nxt = '0;
    end else if ((state_q == ST_RESET_GT) || (state_q == ST_WAIT_SYNC) ||
                 (state_q == ST_WAIT_HSHAKE) || (state_q == ST_BACKOFF)) begin
      timer_nxt = timer_q + TIMER_W'(1);
    end

    gt_reset_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_RESET_GT) ||
                   (state_nxt == ST_BACKOFF) || (state_nxt == ST_FAULT);
    stop_nxt     = (state_nxt != ST_LINK_UP);
    link_up_nxt  = (state_nxt == ST_LINK_UP);
    fault_nxt    = (state_nxt == ST_FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      fail_cnt_q   <= 8'd0;
      link_drops_q <= 16'd0;
      gt_reset_out <= 1'b1;
      stop_out     <= 1'b1;
      link_up_out  <= 1'b0;
      fault_out    <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      timer_q      <= timer_nxt;
      fail_cnt_q   <= fail_cnt_nxt;
      link_drops_q <= link_drops_nxt;
      gt_reset_out <= gt_reset_nxt;
      stop_out     <= stop_nxt;
      link_up_out  <= link_up_nxt;
      fault_out    <= fault_nxt;
    end
  end

  assign state_out      = state_q;
  assign fail_cnt_out   = fail_cnt_q;
  assign link_drops_out = link_drops_q;

  // Packet gate: pass-through when up, stall or discard when down
  assign pkt_data_out = pkt_data_in;
  assign pkt_vld_out  = link_up_out & pkt_vld_in;
  assign pkt_rdy_out  = link_up_out ? pkt_rdy_in : DROP_WHEN_DOWN;

endmodule

// File: tb/tb_hssl_link_controller.sv
// Directed bench for hssl_link_controller: bring-up, timeouts, fault, link drops,
// packet gating (stall and drop variants) and asynchronous reset.
module tb_hssl_link_controller;

  localparam int unsigned PB = 72;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [1:0]    sync;
  logic          hs;
  logic          mm;
  logic [PB-1:0] pkt_data_in;
  logic          pkt_vld_in;
  logic          pkt_rdy_in;

  logic          gt_reset, stop, link_up, fault;
  logic [2:0]    state;
  logic [7:0]    fail_cnt;
  logic [15:0]   drops;
  logic          pkt_rdy_out;
  logic [PB-1:0] pkt_data_out;
  logic          pkt_vld_out;

  logic          gt_reset1, stop1, link_up1, fault1;
  logic [2:0]    state1;
  logic [7:0]    fail_cnt1;
  logic [15:0]   drops1;
  logic          pkt_rdy_out1;
  logic [PB-1:0] pkt_data_out1;
  logic          pkt_vld_out1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hssl_link_controller #(
    .RST_CYCLES(4), .SYNC_TIMEOUT(8), .HSHAKE_TIMEOUT(8), .BACKOFF_CYCLES(3),
    .MAX_RETRIES(2), .PACKET_BITS(PB), .DROP_WHEN_DOWN(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .enable_in(enable), .loss_of_sync_state_in(sync),
    .handshake_complete_in(hs), .version_mismatch_in(mm),
    .gt_reset_out(gt_reset), .stop_out(stop), .link_up_out(link_up), .fault_out(fault),
    .state_out(state), .fail_cnt_out(fail_cnt), .link_drops_out(drops),
    .pkt_data_in(pkt_data_in), .pkt_vld_in(pkt_vld_in), .pkt_rdy_out(pkt_rdy_out),
    .pkt_data_out(pkt_data_out), .pkt_vld_out(pkt_vld_out), .pkt_rdy_in(pkt_rdy_in)
  );

  hssl_link_controller #(
    .RST_CYCLES(4), .SYNC_TIMEOUT(8), .HSHAKE_TIMEOUT(8), .BACKOFF_CYCLES(3),
    .MAX_RETRIES(2), .PACKET_BITS(PB), .DROP_WHEN_DOWN(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .enable_in(enable), .loss_of_sync_state_in(sync),
    .handshake_complete_in(hs), .version_mismatch_in(mm),
    .gt_reset_out(gt_reset1), .stop_out(stop1), .link_up_out(link_up1), .fault_out(fault1),
    .state_out(state1), .fail_cnt_out(fail_cnt1), .link_drops_out(drops1),
    .pkt_data_in(pkt_data_in), .pkt_vld_in(pkt_vld_in), .pkt_rdy_out(pkt_rdy_out1),
    .pkt_data_out(pkt_data_out1), .pkt_vld_out(pkt_vld_out1), .pkt_rdy_in(pkt_rdy_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; sync = 2'b10; hs = 1'b0; mm = 1'b0;
    pkt_data_in = '0; pkt_vld_in = 1'b1; pkt_rdy_in = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if ({gt_reset, stop, link_up, fault} !== 4'b1100) begin failures++; $display("FAIL reset_flags got=%b exp=1100", {gt_reset, stop, link_up, fault}); end
    checks++; if ({fail_cnt, drops} !== 24'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", fail_cnt, drops); end
    checks++; if (pkt_vld_out !== 1'b0) begin failures++; $display("FAIL reset_pkt_vld got=%b exp=0", pkt_vld_out); end
  endtask

  task automatic test_bring_up();
    logic [2:0] exp;
    do_reset();
    enable = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      sync = (k >= 6) ? 2'b00 : 2'b10;
      hs   = (k >= 9);
      tick();
      exp = (k <= 4) ? 3'd1 : (k == 5) ? 3'd2 : (k <= 8) ? 3'd3 : 3'd4;
      checks++; if (state !== exp) begin failures++; $display("FAIL bringup_state k=%0d got=%0d exp=%0d", k, state, exp); end
      checks++; if (gt_reset !== (k <= 4)) begin failures++; $display("FAIL bringup_gt_reset k=%0d got=%b exp=%b", k, gt_reset, (k <= 4)); end
    end
    checks++; if ({stop, link_up, fault} !== 3'b010) begin failures++; $display("FAIL bringup_flags got=%b exp=010", {stop, link_up, fault}); end
    checks++; if (fail_cnt !== 8'd0) begin failures++; $display("FAIL bringup_fail_cnt got=%0d exp=0", fail_cnt); end
  endtask

  // Entered with both instances in LINK_UP, sync=00 and handshake=1
  task automatic test_link_drop();
    logic [2:0] exp;
    sync = 2'b01;
    tick();
    sync = 2'b00;
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL drop_state got=%0d exp=5", state); end
    checks++; if (drops !== 16'd1) begin failures++; $display("FAIL drop_count got=%0d exp=1", drops); end
    checks++; if (fail_cnt !== 8'd1) begin failures++; $display("FAIL drop_fail_cnt got=%0d exp=1", fail_cnt); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp = (k <= 2) ? 3'd5 : (k <= 6) ? 3'd1 : (k == 7) ? 3'd2 : (k == 8) ? 3'd3 : 3'd4;
      checks++; if (state !== exp) begin failures++; $display("FAIL retry_state k=%0d got=%0d exp=%0d", k, state, exp); end
    end
    checks++; if (fail_cnt !== 8'd0) begin failures++; $display("FAIL relink_fail_cnt got=%0d exp=0", fail_cnt); end
    force dut.link_drops_q = 16'hFFFE;
    tick();
    release dut.link_drops_q;
    checks++; if (drops !== 16'hFFFE) begin failures++; $display("FAIL preload_drops got=%h exp=fffe", drops); end
    sync = 2'b01;
    tick();
    sync = 2'b00;
    checks++; if (drops !== 16'hFFFF) begin failures++; $display("FAIL drops_to_max got=%h exp=ffff", drops); end
    for (int k = 1; k <= 9; k++) tick();
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL relink2_state got=%0d exp=4", state); end
    sync = 2'b01;
    tick();
    sync = 2'b00;
    checks++; if (drops !== 16'hFFFF) begin failures++; $display("FAIL drops_saturate got=%h exp=ffff", drops); end
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL drop2_state got=%0d exp=5", state); end
  endtask

  task automatic test_sync_timeout();
    logic [2:0] exp;
    do_reset();
    enable = 1'b1;
    sync = 2'b10;
    for (int k = 1; k <= 28; k++) begin
      tick();
      exp = (k <= 4) ? 3'd1 : (k <= 12) ? 3'd2 : (k <= 15) ? 3'd5 : (k <= 19) ? 3'd1 : (k <= 27) ? 3'd2 : 3'd6;
      checks++; if (state !== exp) begin failures++; $display("FAIL timeout_state k=%0d got=%0d exp=%0d", k, state, exp); end
      if (k == 16) begin
        checks++; if (fail_cnt !== 8'd1) begin failures++; $display("FAIL timeout_fail_cnt1 got=%0d exp=1", fail_cnt); end
      end
      if (k == 27) begin
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL timeout_early_fault got=%b exp=0", fault); end
      end
    end
    checks++; if (fail_cnt !== 8'd2) begin failures++; $display("FAIL timeout_fail_cnt2 got=%0d exp=2", fail_cnt); end
    checks++; if ({fault, gt_reset, stop} !== 3'b111) begin failures++; $display("FAIL timeout_fault_flags got=%b exp=111", {fault, gt_reset, stop}); end
  endtask

  task automatic test_version_mismatch();
    do_reset();
    enable = 1'b1;
    sync = 2'b00;
    for (int k = 1; k <= 6; k++) tick();
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL mm_pre_state got=%0d exp=3", state); end
    mm = 1'b1; hs = 1'b1;
    tick();
    checks++; if (state !== 3'd6) begin failures++; $display("FAIL mm_state got=%0d exp=6", state); end
    checks++; if ({fault, link_up, fail_cnt} !== {2'b10, 8'd0}) begin failures++; $display("FAIL mm_flags got=%b/%0d exp=10/0", {fault, link_up}, fail_cnt); end
    enable = 1'b0; mm = 1'b0; hs = 1'b0;
    tick();
    checks++; if ({state, fault} !== {3'd0, 1'b0}) begin failures++; $display("FAIL mm_idle got=%0d/%b exp=0/0", state, fault); end
    enable = 1'b1;
    tick();
    checks++; if ({state, gt_reset, fail_cnt} !== {3'd1, 1'b1, 8'd0}) begin failures++; $display("FAIL mm_restart got=%0d/%b/%0d exp=1/1/0", state, gt_reset, fail_cnt); end
  endtask

  task automatic test_packet_gate();
    logic [PB-1:0] d;
    d = 72'h12_3456_789A_BCDE_F012;
    do_reset();
    pkt_data_in = d; pkt_vld_in = 1'b1; pkt_rdy_in = 1'b1;
    #1;
    checks++; if ({pkt_vld_out, pkt_vld_out1} !== 2'b00) begin failures++; $display("FAIL gate_down_vld got=%b exp=00", {pkt_vld_out, pkt_vld_out1}); end
    checks++; if ({pkt_rdy_out, pkt_rdy_out1} !== 2'b01) begin failures++; $display("FAIL gate_down_rdy got=%b exp=01", {pkt_rdy_out, pkt_rdy_out1}); end
    enable = 1'b1; sync = 2'b00; hs = 1'b1;
    for (int k = 1; k <= 6; k++) tick();
    checks++; if ({pkt_vld_out, pkt_vld_out1, pkt_rdy_out, pkt_rdy_out1} !== 4'b0001) begin failures++; $display("FAIL gate_pre_up got=%b exp=0001", {pkt_vld_out, pkt_vld_out1, pkt_rdy_out, pkt_rdy_out1}); end
    tick();
    checks++; if ({link_up, link_up1, pkt_vld_out, pkt_vld_out1} !== 4'b1111) begin failures++; $display("FAIL gate_up_vld got=%b exp=1111", {link_up, link_up1, pkt_vld_out, pkt_vld_out1}); end
    checks++; if (pkt_data_out !== d || pkt_data_out1 !== d) begin failures++; $display("FAIL gate_up_data got=%h/%h exp=%h", pkt_data_out, pkt_data_out1, d); end
    checks++; if ({pkt_rdy_out, pkt_rdy_out1} !== 2'b11) begin failures++; $display("FAIL gate_up_rdy1 got=%b exp=11", {pkt_rdy_out, pkt_rdy_out1}); end
    pkt_rdy_in = 1'b0;
    #1;
    checks++; if ({pkt_rdy_out, pkt_rdy_out1} !== 2'b00) begin failures++; $display("FAIL gate_up_rdy0 got=%b exp=00", {pkt_rdy_out, pkt_rdy_out1}); end
    sync = 2'b01;
    tick();
    checks++; if ({link_up, pkt_vld_out, pkt_vld_out1} !== 3'b000) begin failures++; $display("FAIL gate_drop_vld got=%b exp=000", {link_up, pkt_vld_out, pkt_vld_out1}); end
    checks++; if ({pkt_rdy_out, pkt_rdy_out1} !== 2'b01) begin failures++; $display("FAIL gate_drop_rdy got=%b exp=01", {pkt_rdy_out, pkt_rdy_out1}); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp;
    do_reset();
    enable = 1'b1; sync = 2'b00; hs = 1'b0;
    for (int k = 1; k <= 11; k++) tick();
    checks++; if ({state, gt_reset} !== {3'd3, 1'b0}) begin failures++; $display("FAIL mid_pre got=%0d/%b exp=3/0", state, gt_reset); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL mid_async_state got=%0d exp=0", state); end
    checks++; if ({gt_reset, stop, link_up, fault} !== 4'b1100) begin failures++; $display("FAIL mid_async_flags got=%b exp=1100", {gt_reset, stop, link_up, fault}); end
    checks++; if ({fail_cnt, drops} !== 24'd0) begin failures++; $display("FAIL mid_async_counts got=%0d/%0d exp=0/0", fail_cnt, drops); end
    #1;
    reset = 1'b0;
    hs = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp = (k <= 4) ? 3'd1 : (k == 5) ? 3'd2 : (k == 6) ? 3'd3 : 3'd4;
      checks++; if (state !== exp) begin failures++; $display("FAIL mid_restart k=%0d got=%0d exp=%0d", k, state, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_bring_up();
    test_link_drop();
    test_sync_timeout();
    test_version_mismatch();
    test_packet_gate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
